// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame-format levels and default
// sizing. The transmitter uses the same constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int DEFAULT_DATA_BITS  = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, received byte and status pulses out.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEFAULT_DATA_BITS
) ();

  logic                 rx;
  logic [DATA_BITS-1:0] data;
  logic                 rx_done;
  logic                 frame_error;

  modport master (
    output rx,
    input  data,
    input  rx_done,
    input  frame_error
  );

  modport slave (
    input  rx,
    output data,
    output rx_done,
    output frame_error
  );

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer with a selectable reset level; also serves as a reset
// release synchronizer when d is tied high and RESET_VALUE is 0.
module uart_sync #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic s_tick,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge s_tick or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver: recovers frames from the async rx line and
// reports each byte with a one-tick rx_done or frame_error pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input logic     s_tick,
  input logic     reset,
  uart_rx_if.slave bus
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic                 reset_sync;
  logic                 rx_s;
  logic                 rx_q;
  rx_state_t            state;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] data_q;
  logic                 done_q;
  logic                 ferr_q;

  // Reset asserts asynchronously but releases on an s_tick edge.
  uart_sync #(.RESET_VALUE(1'b0)) u_reset_sync (
    .s_tick (s_tick),
    .reset  (reset),
    .d      (1'b1),
    .q      (reset_sync)
  );

  uart_sync #(.RESET_VALUE(IDLE_LEVEL)) u_rx_sync (
    .s_tick (s_tick),
    .reset  (reset_sync),
    .d      (bus.rx),
    .q      (rx_s)
  );

  always_ff @(posedge s_tick or negedge reset_sync) begin
    if (!reset_sync) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
      rx_q     <= IDLE_LEVEL;
    end else begin
      done_q <= 1'b0;
      ferr_q <= 1'b0;
      rx_q   <= rx_s;
      unique case (state)
        // Only a genuine high-to-low edge starts a frame, so a held-low line is ignored.
        IDLE: begin
          if (rx_q == IDLE_LEVEL && rx_s == START_BIT) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (tick_cnt == HALF_LAST) begin
            tick_cnt <= '0;
            if (rx_s == START_BIT) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == FULL_LAST) begin
            tick_cnt <= '0;
            shift    <= {rx_s, shift[DATA_BITS-1:1]};
            bit_idx  <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (tick_cnt == FULL_LAST) begin
            tick_cnt <= '0;
            state    <= IDLE;
            if (rx_s == STOP_BIT) begin
              data_q <= shift;
              done_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          tick_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.data        = data_q;
  assign bus.rx_done     = done_q;
  assign bus.frame_error = ferr_q;

endmodule
